// File: rtl/ahb_sram_pkg.sv
// Shared encodings and helpers for the AHB-Lite SRAM bank.
// Latency: n/a (types, constants and combinational helpers only).
// Backpressure: n/a.
package ahb_sram_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam int MAX_LANES = 8;

  // Lane mask for a transfer of 2**size bytes starting at byte lane lo.
  // Callers truncate the result to their own lane count.
  function automatic logic [MAX_LANES-1:0] byte_strobe(input logic [2:0] size,
                                                       input logic [2:0] lo);
    logic [MAX_LANES:0] ones;
    ones = (9'd1 << (4'd1 << size)) - 9'd1;
    return MAX_LANES'(ones << lo);
  endfunction

  // Low address bits that must be zero for a transfer of 2**size bytes.
  function automatic logic [2:0] size_mask(input logic [2:0] size);
    return 3'((4'd1 << size) - 4'd1);
  endfunction

endpackage

// File: rtl/sram_be_array.sv
// Byte-writable SRAM: one synchronous read-first read port plus an independent write port.
// Latency: read data appears the cycle after rd_en; writes land at the clock edge.
// Backpressure: none, both ports accept every cycle.
// Ports: clk; rd_en/rd_addr -> rd_data (held when rd_en low); wr_be/wr_addr/wr_data.
module sram_be_array #(
  parameter int DEPTH = 512,
  parameter int LANES = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [8*LANES-1:0]   rd_data,
  input  logic [LANES-1:0]     wr_be,
  input  logic [AW-1:0]        wr_addr,
  input  logic [8*LANES-1:0]   wr_data
);

  logic [8*LANES-1:0] mem [DEPTH];

  // Read-first: a read and a write to the same word on one edge returns the old word.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    for (int i = 0; i < LANES; i++) begin
      if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/ahb_sram_bank.sv
// AHB-Lite memory slave with byte strobes, write-to-read forwarding and decode errors.
// Latency: writes zero-wait; reads 1 + READ_WAIT cycles from accept; errors two cycles.
// Backpressure: HREADYOUT low during read wait states and the first ERROR cycle.
// Ports: HCLK/HRESET; AHB address phase (HSEL, HREADYIN, HTRANS, HBURST, HSIZE, HADDR,
//        HWRITE); HWDATA in the data phase; HRDATA/HRESP/HREADYOUT responses.
module ahb_sram_bank
  import ahb_sram_pkg::*;
#(
  parameter int AHB_DWIDTH    = 32,
  parameter int AHB_AWIDTH    = 32,
  parameter int SIZE_IN_BYTES = 2048,
  parameter int READ_WAIT     = 0,
  parameter int ADD_WIDTH     = $clog2(SIZE_IN_BYTES)
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic                  HREADYIN,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HBURST,
  input  logic [2:0]            HSIZE,
  input  logic [AHB_AWIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [AHB_DWIDTH-1:0] HWDATA,
  output logic [AHB_DWIDTH-1:0] HRDATA,
  output logic [1:0]            HRESP,
  output logic                  HREADYOUT
);

  localparam int LANES = AHB_DWIDTH / 8;
  localparam int LB    = $clog2(LANES);
  localparam int WI_W  = ADD_WIDTH - LB;
  localparam int DEPTH = SIZE_IN_BYTES / LANES;

  state_e                state;
  logic [2:0]            cnt;
  logic                  ready_q;
  logic [1:0]            resp_q;
  logic [AHB_DWIDTH-1:0] hold_q;

  logic [WI_W-1:0]       wr_idx_q;
  logic [LANES-1:0]      wr_strb_q;
  logic                  fwd_hit;
  logic [LANES-1:0]      fwd_strb;
  logic [AHB_DWIDTH-1:0] fwd_data;

  logic [AHB_DWIDTH-1:0] rd_data;
  logic [AHB_DWIDTH-1:0] rd_word;
  logic [LANES-1:0]      wr_be;

  // Bursts need no tracking: every beat carries its own address.
  logic unused_ok;
  assign unused_ok = ^{HBURST, HTRANS[0]};

  // ---------------- address-phase decode ----------------
  logic [2:0]       lo3;
  logic             dec_err;
  logic [LANES-1:0] strb;
  logic [WI_W-1:0]  widx;
  logic             can_accept;
  logic             accept;
  logic             rd_done;

  assign lo3     = 3'(HADDR[LB-1:0]);
  assign dec_err = (HSIZE > 3'(LB))
                 | ((lo3 & size_mask(HSIZE)) != 3'd0)
                 | ({1'b0, HADDR} >= (AHB_AWIDTH+1)'(SIZE_IN_BYTES));
  assign strb    = LANES'(byte_strobe(HSIZE, lo3));
  assign widx    = HADDR[ADD_WIDTH-1:LB];

  assign rd_done    = (state == ST_RD) && (cnt == 3'd0);
  // ERR1 and read wait states never take a new transfer.
  assign can_accept = (state == ST_IDLE) || (state == ST_WR) || (state == ST_ERR2) || rd_done;
  assign accept     = HSEL & HREADYIN & HTRANS[1] & can_accept;

  // ---------------- array ----------------
  // The pending write commits at the edge ending the WR cycle, unless reset drops it.
  assign wr_be = (state == ST_WR && !HRESET) ? wr_strb_q : '0;

  sram_be_array #(
    .DEPTH (DEPTH),
    .LANES (LANES)
  ) u_array (
    .clk     (HCLK),
    .rd_en   (accept & ~HWRITE & ~dec_err),
    .rd_addr (widx),
    .rd_data (rd_data),
    .wr_be   (wr_be),
    .wr_addr (wr_idx_q),
    .wr_data (HWDATA)
  );

  // A read accepted while the previous write is still in its data phase sees the
  // array's old word; patch in the lanes that write was carrying.
  always_comb begin
    rd_word = rd_data;
    for (int i = 0; i < LANES; i++) begin
      if (fwd_hit && fwd_strb[i]) rd_word[8*i +: 8] = fwd_data[8*i +: 8];
    end
  end

  always_ff @(posedge HCLK) begin
    if (accept) begin
      wr_idx_q  <= widx;
      wr_strb_q <= strb;
      fwd_hit   <= (state == ST_WR) && !HWRITE && (widx == wr_idx_q);
      fwd_strb  <= wr_strb_q;
      fwd_data  <= HWDATA;
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= ST_IDLE;
      cnt     <= 3'd0;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
      hold_q  <= '0;
    end else begin
      if (rd_done) hold_q <= rd_word;
      if (accept) begin
        if (dec_err) begin
          state   <= ST_ERR1;
          ready_q <= 1'b0;
          resp_q  <= HRESP_ERROR;
        end else if (HWRITE) begin
          state   <= ST_WR;
          ready_q <= 1'b1;
          resp_q  <= HRESP_OKAY;
        end else begin
          state   <= ST_RD;
          cnt     <= 3'(READ_WAIT);
          ready_q <= (READ_WAIT == 0);
          resp_q  <= HRESP_OKAY;
        end
      end else begin
        case (state)
          ST_RD: begin
            if (cnt != 3'd0) begin
              cnt     <= cnt - 3'd1;
              ready_q <= (cnt == 3'd1);
            end else begin
              state   <= ST_IDLE;
              ready_q <= 1'b1;
            end
            resp_q <= HRESP_OKAY;
          end
          ST_ERR1: begin
            state   <= ST_ERR2;
            ready_q <= 1'b1;
            resp_q  <= HRESP_ERROR;
          end
          default: begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
          end
        endcase
      end
    end
  end

  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;
  assign HRDATA    = rd_done ? rd_word : hold_q;

endmodule
